// File: rtl/poly_dds_voice_bank.sv
// Polyphonic DDS tone generator: key-press voice allocation with round-robin stealing,
// per-voice phase accumulators with triangle/square shaping, mixed into a first-order PWM bit.
module poly_dds_voice_bank #(
  parameter int VOICES  = 4,
  parameter int KEYS    = 13,
  parameter int PHASE_W = 25,
  parameter int SAMP_W  = 12,
  parameter int FCW_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [KEYS-1:0]       key_n_i,
  input  logic [KEYS*FCW_W-1:0] fcw_tab_i,
  input  logic [2:0]            octave_i,
  input  logic                  wave_sel_i,
  output logic                  pwm_out_o,
  output logic [VOICES-1:0]     active_mask_o,
  output logic                  steal_pulse_o
);

  localparam int MIX_W  = SAMP_W + $clog2(VOICES);
  localparam int KEY_IW = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int VIDX_W = $clog2(VOICES);
  localparam int FCWE_W = FCW_W + 3;

  logic [KEYS-1:0]    key_q;
  logic [KEYS-1:0]    pending_q, pending_d;
  logic [VOICES-1:0]  busy_q, busy_d;
  logic [KEY_IW-1:0]  vkey_q  [VOICES];
  logic [KEY_IW-1:0]  vkey_d  [VOICES];
  logic [PHASE_W-1:0] phase_q [VOICES];
  logic [PHASE_W-1:0] phase_d [VOICES];
  logic [VIDX_W-1:0]  rr_q, rr_d;
  logic               steal_q, steal_d;
  logic [MIX_W-1:0]   mix_q, mix_d;
  logic [MIX_W:0]     acc_q, acc_d;

  logic              svc_valid;
  logic [KEY_IW-1:0] svc_key;
  logic              hit;
  logic [VIDX_W-1:0] hit_v;
  logic              free_valid;
  logic [VIDX_W-1:0] free_v;
  logic [VIDX_W-1:0] alloc_v;
  logic              do_alloc;

  logic [1:0]        shift;
  logic [FCW_W-1:0]  fcw_arr [KEYS];
  logic [FCWE_W-1:0] fcw_eff [VOICES];
  logic [SAMP_W:0]   tword   [VOICES];
  logic [SAMP_W-1:0] samp    [VOICES];
  logic [VOICES-1:0] rel;

  always_comb begin
    unique case (octave_i)
      3'd0, 3'd1: shift = 2'd0;
      3'd2:       shift = 2'd1;
      3'd3:       shift = 2'd2;
      default:    shift = 2'd3;
    endcase
    for (int k = 0; k < KEYS; k++) begin
      fcw_arr[k] = fcw_tab_i[k*FCW_W +: FCW_W];
    end
  end

  // One pending press per cycle is serviced; a key already held by a voice only restarts its phase.
  always_comb begin
    svc_valid = 1'b0;
    svc_key   = '0;
    for (int i = KEYS-1; i >= 0; i--) begin
      if (pending_q[i] && !key_n_i[i]) begin
        svc_valid = 1'b1;
        svc_key   = KEY_IW'(i);
      end
    end
    hit   = 1'b0;
    hit_v = '0;
    free_valid = 1'b0;
    free_v     = '0;
    for (int v = VOICES-1; v >= 0; v--) begin
      if (busy_q[v] && vkey_q[v] == svc_key) begin
        hit   = 1'b1;
        hit_v = VIDX_W'(v);
      end
      if (!busy_q[v]) begin
        free_valid = 1'b1;
        free_v     = VIDX_W'(v);
      end
    end
    alloc_v  = free_valid ? free_v : rr_q;
    do_alloc = svc_valid && !hit;
    steal_d  = do_alloc && !free_valid;
    pending_d = (pending_q & ~key_n_i) | (key_q & ~key_n_i);
    if (svc_valid) pending_d[svc_key] = 1'b0;
    rr_d = rr_q;
    if (steal_d) rr_d = (rr_q == VIDX_W'(VOICES-1)) ? '0 : rr_q + 1'b1;
  end

  always_comb begin
    rel    = '0;
    busy_d = '0;
    for (int v = 0; v < VOICES; v++) begin
      fcw_eff[v] = {3'b000, fcw_arr[vkey_q[v]]} << shift;
      rel[v]     = busy_q[v] && key_n_i[vkey_q[v]];
      busy_d[v]  = busy_q[v] && !rel[v];
      vkey_d[v]  = vkey_q[v];
      phase_d[v] = busy_d[v] ? phase_q[v] + PHASE_W'(fcw_eff[v]) : '0;
      if (svc_valid && hit && hit_v == VIDX_W'(v)) phase_d[v] = '0;
      if (do_alloc && alloc_v == VIDX_W'(v)) begin
        busy_d[v]  = 1'b1;
        vkey_d[v]  = svc_key;
        phase_d[v] = '0;
      end
      tword[v] = phase_q[v][PHASE_W-1 -: SAMP_W+1];
      if (!busy_q[v])      samp[v] = '0;
      else if (wave_sel_i) samp[v] = tword[v][SAMP_W] ? {SAMP_W{1'b1}} : '0;
      else                 samp[v] = tword[v][SAMP_W] ? ~tword[v][SAMP_W-1:0] : tword[v][SAMP_W-1:0];
    end
  end

  always_comb begin
    mix_d = '0;
    for (int v = 0; v < VOICES; v++) begin
      mix_d = mix_d + MIX_W'(samp[v]);
    end
    acc_d = {1'b0, acc_q[MIX_W-1:0]} + {1'b0, mix_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q     <= '1;
      pending_q <= '0;
      busy_q    <= '0;
      rr_q      <= '0;
      steal_q   <= 1'b0;
      mix_q     <= '0;
      acc_q     <= '0;
      for (int v = 0; v < VOICES; v++) begin
        vkey_q[v]  <= '0;
        phase_q[v] <= '0;
      end
    end else begin
      key_q     <= key_n_i;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      rr_q      <= rr_d;
      steal_q   <= steal_d;
      mix_q     <= mix_d;
      acc_q     <= acc_d;
      for (int v = 0; v < VOICES; v++) begin
        vkey_q[v]  <= vkey_d[v];
        phase_q[v] <= phase_d[v];
      end
    end
  end

  assign pwm_out_o     = acc_q[MIX_W];
  assign active_mask_o = busy_q;
  assign steal_pulse_o = steal_q;

endmodule

// File: tb/tb_poly_dds_voice_bank.sv
// Scenario bench for poly_dds_voice_bank: expectations are queued when keys are driven
// and popped against the DUT once the documented latency has elapsed.
module tb_poly_dds_voice_bank;

  localparam int KEYS  = 13;
  localparam int FCW_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [KEYS-1:0]       key_n;
  logic [KEYS*FCW_W-1:0] fcw_tab;
  logic [2:0]            octave;
  logic                  wave_sel;
  logic                  pwm_out;
  logic [3:0]            active_mask;
  logic                  steal_pulse;

  typedef struct {
    string       name;
    int unsigned val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  poly_dds_voice_bank #(
    .VOICES(4), .KEYS(KEYS), .PHASE_W(25), .SAMP_W(12), .FCW_W(FCW_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .key_n_i      (key_n),
    .fcw_tab_i    (fcw_tab),
    .octave_i     (octave),
    .wave_sel_i   (wave_sel),
    .pwm_out_o    (pwm_out),
    .active_mask_o(active_mask),
    .steal_pulse_o(steal_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string n, input int unsigned v);
    sb.push_back('{n, v});
  endtask

  // Reference sample for a 25-bit phase, 12-bit samples taken from the top 13 phase bits.
  function automatic int unsigned samp_of(input longint unsigned ph, input bit sq);
    longint unsigned p;
    int unsigned t;
    p = ph % (64'd1 << 25);
    t = 32'(p >> 12);
    if (sq) return t[12] ? 32'd4095 : 32'd0;
    return t[12] ? ((~t) & 32'd4095) : (t & 32'd4095);
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    push_exp("rst_mask", 0); push_exp("rst_pwm", 0); push_exp("rst_steal", 0);
    push_exp("rst_mix", 0);  push_exp("rst_acc", 0);
    tick(); tick();
    e = sb.pop_front(); checks++;
    if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
    e = sb.pop_front(); checks++;
    if (pwm_out !== 1'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, pwm_out, e.val); end
    e = sb.pop_front(); checks++;
    if (steal_pulse !== 1'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, steal_pulse, e.val); end
    e = sb.pop_front(); checks++;
    if (dut.mix_q !== 14'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.mix_q, e.val); end
    e = sb.pop_front(); checks++;
    if (dut.acc_q !== 15'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.acc_q, e.val); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_key();
    exp_t e;
    int unsigned p;
    octave = 3'd1; wave_sel = 1'b0;
    push_exp("single_mask_E", 0); push_exp("single_mask_E1", 1); push_exp("single_phase_E1", 0);
    push_exp("single_phase_E2", 308); push_exp("single_phase_E3", 616);
    key_n[9] = 1'b0;
    tick();
    e = sb.pop_front(); checks++;
    if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
    tick();
    e = sb.pop_front(); checks++;
    if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
    e = sb.pop_front(); checks++;
    if (dut.phase_q[0] !== 25'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.phase_q[0], e.val); end
    for (int s = 0; s < 2; s++) begin
      tick();
      e = sb.pop_front(); checks++;
      if (dut.phase_q[0] !== 25'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.phase_q[0], e.val); end
    end
    repeat (19998) tick();
    p = 308 * 20000;
    push_exp("single_phase_k20000", p);
    push_exp("single_mix_tri", samp_of(p, 1'b0));
    e = sb.pop_front(); checks++;
    if (dut.phase_q[0] !== 25'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.phase_q[0], e.val); end
    tick();
    e = sb.pop_front(); checks++;
    if (dut.mix_q !== 14'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.mix_q, e.val); end
    p = 308 * 20001;
    octave = 3'd3;
    push_exp("octave3_step", p + 1232);
    tick();
    e = sb.pop_front(); checks++;
    if (dut.phase_q[0] !== 25'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.phase_q[0], e.val); end
    octave = 3'd6;
    push_exp("octave6_step", p + 1232 + 2464);
    tick();
    e = sb.pop_front(); checks++;
    if (dut.phase_q[0] !== 25'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.phase_q[0], e.val); end
    key_n[9] = 1'b1;
    push_exp("single_release_mask", 0); push_exp("single_release_phase", 0);
    tick();
    e = sb.pop_front(); checks++;
    if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
    e = sb.pop_front(); checks++;
    if (dut.phase_q[0] !== 25'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.phase_q[0], e.val); end
    octave = 3'd1;
  endtask

  task automatic test_chord();
    exp_t e;
    int ones;
    int unsigned m;
    octave = 3'd4; wave_sel = 1'b1;
    push_exp("chord_mask_E", 0); push_exp("chord_mask_E1", 1);
    push_exp("chord_mask_E2", 3); push_exp("chord_mask_E3", 7);
    key_n[0] = 1'b0; key_n[4] = 1'b0; key_n[7] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      e = sb.pop_front(); checks++;
      if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
    end
    push_exp("chord_vkey0", 0); push_exp("chord_vkey1", 4); push_exp("chord_vkey2", 7);
    for (int v = 0; v < 3; v++) begin
      e = sb.pop_front(); checks++;
      if (dut.vkey_q[v] !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.vkey_q[v], e.val); end
    end
    repeat (11998) tick();
    push_exp("chord_square_mix", 12285);
    tick();
    e = sb.pop_front(); checks++;
    if (dut.mix_q !== 14'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.mix_q, e.val); end
    push_exp("chord_pwm_ones", 767);
    ones = 0;
    repeat (1024) begin
      tick();
      if (pwm_out === 1'b1) ones++;
    end
    e = sb.pop_front(); checks++;
    if (ones < int'(e.val) || ones > int'(e.val) + 1) begin errors++; $display("[TB] FAIL %s got %0d expected %0d..%0d", e.name, ones, e.val, e.val + 1); end
    wave_sel = 1'b0;
    m = samp_of(64'(1600) * 13025, 1'b0) + samp_of(64'(1984) * 13024, 1'b0) + samp_of(64'(2272) * 13023, 1'b0);
    push_exp("chord_tri_mix", m);
    tick();
    e = sb.pop_front(); checks++;
    if (dut.mix_q !== 14'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.mix_q, e.val); end
    key_n[0] = 1'b1; key_n[4] = 1'b1; key_n[7] = 1'b1;
    push_exp("chord_release_mask", 0);
    tick();
    e = sb.pop_front(); checks++;
    if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
    octave = 3'd1;
  endtask

  task automatic test_steal();
    exp_t e;
    int seq[4] = '{1, 2, 3, 5};
    foreach (seq[j]) begin
      key_n[seq[j]] = 1'b0;
      tick(); tick();
    end
    push_exp("steal_full_mask", 15); push_exp("steal_idle", 0);
    e = sb.pop_front(); checks++;
    if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
    e = sb.pop_front(); checks++;
    if (steal_pulse !== 1'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, steal_pulse, e.val); end
    for (int n = 0; n < 2; n++) begin
      key_n[n == 0 ? 6 : 8] = 1'b0;
      push_exp("steal_pulse_hi", 1); push_exp("steal_vkey", n == 0 ? 6 : 8);
      push_exp("steal_rr", n + 1); push_exp("steal_pulse_lo", 0);
      tick(); tick();
      e = sb.pop_front(); checks++;
      if (steal_pulse !== 1'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, steal_pulse, e.val); end
      e = sb.pop_front(); checks++;
      if (dut.vkey_q[n] !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.vkey_q[n], e.val); end
      e = sb.pop_front(); checks++;
      if (dut.rr_q !== 2'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.rr_q, e.val); end
      tick();
      e = sb.pop_front(); checks++;
      if (steal_pulse !== 1'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, steal_pulse, e.val); end
    end
  endtask

  task automatic test_race();
    exp_t e;
    key_n[10] = 1'b0;
    tick();
    key_n[10] = 1'b1;
    push_exp("race_pending", 0); push_exp("race_mask", 15); push_exp("race_steal", 0);
    push_exp("race_vkey2", 3); push_exp("race_rr", 2);
    tick();
    e = sb.pop_front(); checks++;
    if (dut.pending_q !== 13'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.pending_q, e.val); end
    tick();
    e = sb.pop_front(); checks++;
    if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
    e = sb.pop_front(); checks++;
    if (steal_pulse !== 1'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, steal_pulse, e.val); end
    e = sb.pop_front(); checks++;
    if (dut.vkey_q[2] !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.vkey_q[2], e.val); end
    e = sb.pop_front(); checks++;
    if (dut.rr_q !== 2'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.rr_q, e.val); end
    key_n = '1;
    push_exp("all_release_mask", 0);
    tick();
    e = sb.pop_front(); checks++;
    if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
  endtask

  task automatic test_reset_mid_chord();
    exp_t e;
    bit seen;
    octave = 3'd4; wave_sel = 1'b1;
    key_n[0] = 1'b0; key_n[4] = 1'b0; key_n[7] = 1'b0;
    repeat (4) tick();
    repeat (11000) tick();
    push_exp("mid_pwm_seen", 1);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (pwm_out === 1'b1) seen = 1'b1;
      else tick();
    end
    e = sb.pop_front(); checks++;
    if (seen !== 1'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, seen, e.val); end
    push_exp("mid_rst_mask", 0); push_exp("mid_rst_pwm", 0); push_exp("mid_rst_acc", 0);
    #2 rst_n = 1'b0;
    #1;
    e = sb.pop_front(); checks++;
    if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
    e = sb.pop_front(); checks++;
    if (pwm_out !== 1'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, pwm_out, e.val); end
    tick();
    rst_n = 1'b1;
    e = sb.pop_front(); checks++;
    if (dut.acc_q !== 15'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, dut.acc_q, e.val); end
    push_exp("held_mask_E", 0); push_exp("held_mask_E1", 1);
    push_exp("held_mask_E2", 3); push_exp("held_mask_E3", 7);
    for (int s = 0; s < 4; s++) begin
      tick();
      e = sb.pop_front(); checks++;
      if (active_mask !== 4'(e.val)) begin errors++; $display("[TB] FAIL %s got %0d expected %0d", e.name, active_mask, e.val); end
    end
  endtask

  initial begin
    key_n    = '1;
    octave   = 3'd1;
    wave_sel = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < KEYS; i++) fcw_tab[i*FCW_W +: FCW_W] = 16'(200 + 12 * i);
    test_reset();
    test_single_key();
    test_chord();
    test_steal();
    test_race();
    test_reset_mid_chord();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
